// File: rtl/spi_slave_wide.sv
// spi_slave_wide: SPI slave with a parameterisable word length, all four SPI modes and
// MSB- or LSB-first shifting. The SPI pins are oversampled in the clk domain through
// synchronisers, so clk must be several times faster than spi_clk.
//
// Parameters:
//   WIDTH     word length in bits (4..32)
//   MSB_FIRST 1 = MSB shifted first, 0 = LSB first
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   ena          clock enable for all state (pulses are dropped, not stretched, while low)
//   spi_clk      SPI serial clock (asynchronous to clk)
//   spi_ss       slave select, active-low
//   spi_in       MOSI
//   spi_out      MISO, 0 while deselected
//   mode         {CPOL, CPHA}, captured only while deselected
//   bus_in       transmit word
//   bus_out      last complete received word
//   tx           one-cycle pulse when bus_in is captured
//   rx           one-cycle pulse when bus_out is updated
//   rx_ack       host read acknowledge
//   rx_overrun   sticky: a word completed before the previous one was acknowledged
//   crc_rx_out   CRC-8 (poly 0x07) of the bits received in the current select period,
//                latched with each rx pulse. Present only when SPI_SLAVE_WIDE_CRC_EN
//                is defined.
module spi_slave_wide #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             spi_clk,
  input  logic             spi_ss,
  input  logic             spi_in,
  output logic             spi_out,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] bus_out,
  output logic             tx,
  output logic             rx,
  input  logic             rx_ack,
  output logic             rx_overrun
`ifdef SPI_SLAVE_WIDE_CRC_EN
  ,
  output logic [7:0]       crc_rx_out
`endif
);

  localparam int unsigned CW      = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);
  localparam int unsigned OUT_BIT = (MSB_FIRST != 0) ? WIDTH - 1 : 0;

  // Synchronisers: index 0 is the first stage.
  logic [2:0] sclk_sync_q;
  logic [2:0] ss_sync_q;
  logic [1:0] in_sync_q;

  logic             armed_q, armed_d;
  logic [1:0]       mode_q, mode_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] bus_out_q, bus_out_d;
  logic             rx_q, rx_d;
  logic             tx_q, tx_d;
  logic             unread_q, unread_d;
  logic             overrun_q, overrun_d;

  logic sclk_rise, sclk_fall, ss_fall, active;
  logic sample_edge, shift_edge, word_done, tx_load, din;
  logic [WIDTH-1:0] rx_shifted, tx_shifted;

  assign din       = in_sync_q[1];
  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign ss_fall   = ~ss_sync_q[1] & ss_sync_q[2];
  // armed_q stays low after reset until select has been seen high, so a transfer that
  // was running across reset is ignored until the next select falling edge.
  assign active    = armed_q & ~ss_sync_q[1];

  // CPOL == CPHA samples on the rising edge, otherwise on the falling edge.
  assign sample_edge = active & ((mode_q[1] == mode_q[0]) ? sclk_rise : sclk_fall);
  assign shift_edge  = active & ((mode_q[1] == mode_q[0]) ? sclk_fall : sclk_rise);
  assign word_done   = sample_edge & (cnt_q == LAST);

  // CPHA=0 presents the first bit before any clock, so load on select and on word end.
  // CPHA=1 loads on the leading (shift) edge of each word.
  assign tx_load = mode_q[0] ? (shift_edge & (cnt_q == '0)) : (ss_fall & active) | word_done;

  always_comb begin
    if (MSB_FIRST != 0) begin
      rx_shifted = {rx_sr_q[WIDTH-2:0], din};
      tx_shifted = {tx_sr_q[WIDTH-2:0], 1'b0};
    end else begin
      rx_shifted = {din, rx_sr_q[WIDTH-1:1]};
      tx_shifted = {1'b0, tx_sr_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    mode_d    = ss_sync_q[1] ? mode : mode_q;
    armed_d   = armed_q | ss_sync_q[1];
    cnt_d     = cnt_q;
    rx_sr_d   = rx_sr_q;
    tx_sr_d   = tx_sr_q;
    bus_out_d = bus_out_q;
    rx_d      = 1'b0;
    tx_d      = 1'b0;

    if (!active) begin
      // Deselected (or aborted mid-word): drop any partial word.
      cnt_d   = '0;
      rx_sr_d = '0;
      tx_sr_d = '0;
    end else begin
      if (sample_edge) begin
        rx_sr_d = rx_shifted;
        cnt_d   = word_done ? '0 : cnt_q + CW'(1);
        if (word_done) begin
          bus_out_d = rx_shifted;
          rx_d      = 1'b1;
        end
      end
      if (tx_load) begin
        tx_sr_d = bus_in;
        tx_d    = 1'b1;
      end else if (shift_edge && (cnt_q != '0)) begin
        // In CPHA=0 the shift edge right after a word boundary must not shift: the new
        // word was just loaded with its first bit already on MISO.
        tx_sr_d = tx_shifted;
      end
    end

    // An rx together with rx_ack: the ack covers the older word, the new one is unread.
    unread_d = unread_q;
    if (rx_q)        unread_d = 1'b1;
    else if (rx_ack) unread_d = 1'b0;

    overrun_d = overrun_q;
    if (rx_ack)                overrun_d = 1'b0;
    else if (rx_q && unread_q) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '0;
      in_sync_q   <= '0;
      armed_q     <= 1'b0;
      mode_q      <= '0;
      cnt_q       <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      bus_out_q   <= '0;
      rx_q        <= 1'b0;
      tx_q        <= 1'b0;
      unread_q    <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (ena) begin
      sclk_sync_q <= {sclk_sync_q[1:0], spi_clk};
      ss_sync_q   <= {ss_sync_q[1:0], spi_ss};
      in_sync_q   <= {in_sync_q[0], spi_in};
      armed_q     <= armed_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      bus_out_q   <= bus_out_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      unread_q    <= unread_d;
      overrun_q   <= overrun_d;
    end else begin
      rx_q <= 1'b0;
      tx_q <= 1'b0;
    end
  end

`ifdef SPI_SLAVE_WIDE_CRC_EN
  logic [7:0] crc_q, crc_d, crc_step, crc_out_q, crc_out_d;

  // Bit-serial CRC-8, poly x^8+x^2+x+1, in wire order.
  assign crc_step = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ din) ? 8'h07 : 8'h00);

  always_comb begin
    crc_d     = crc_q;
    crc_out_d = crc_out_q;
    if (!active)          crc_d = '0;
    else if (sample_edge) crc_d = crc_step;
    if (word_done) crc_out_d = crc_step;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q     <= '0;
      crc_out_q <= '0;
    end else if (ena) begin
      crc_q     <= crc_d;
      crc_out_q <= crc_out_d;
    end
  end

  assign crc_rx_out = crc_out_q;
`endif

  assign spi_out    = active ? tx_sr_q[OUT_BIT] : 1'b0;
  assign bus_out    = bus_out_q;
  assign tx         = tx_q;
  assign rx         = rx_q;
  assign rx_overrun = overrun_q;

endmodule

// File: tb/tb_spi_slave_wide.sv
// Directed bench for spi_slave_wide: an 8-bit MSB-first instance and a 16-bit LSB-first
// instance share the SPI pins. A bus-functional SPI master drives frames; expected
// received words go into per-instance queues and are checked on each rx pulse.
module tb_spi_slave_wide;

  localparam int HALF = 80;

  logic        clk, rst, ena, spi_clk, spi_ss, spi_in, rx_ack;
  logic [1:0]  mode;
  logic [7:0]  bus_in8, bus_out8;
  logic [15:0] bus_in16, bus_out16;
  logic        so8, so16, tx8, tx16, rx8, rx16, ovr8, ovr16;
`ifdef SPI_SLAVE_WIDE_CRC_EN
  logic [7:0]  crc8, crc16;
`endif

  int checks   = 0;
  int failures = 0;
  int rx8_cnt  = 0;
  int tx8_cnt  = 0;
  int rx16_cnt = 0;
  bit watch8   = 1'b1;
  bit watch16  = 1'b0;
  logic [1:0]  cur_mode = 2'b00;
  logic [31:0] q8[$];
  logic [31:0] q16[$];

  spi_slave_wide #(.WIDTH(8), .MSB_FIRST(1)) dut8 (
    .clk(clk), .rst(rst), .ena(ena), .spi_clk(spi_clk), .spi_ss(spi_ss), .spi_in(spi_in),
    .spi_out(so8), .mode(mode), .bus_in(bus_in8), .bus_out(bus_out8), .tx(tx8), .rx(rx8),
    .rx_ack(rx_ack), .rx_overrun(ovr8)
`ifdef SPI_SLAVE_WIDE_CRC_EN
    , .crc_rx_out(crc8)
`endif
  );

  spi_slave_wide #(.WIDTH(16), .MSB_FIRST(0)) dut16 (
    .clk(clk), .rst(rst), .ena(ena), .spi_clk(spi_clk), .spi_ss(spi_ss), .spi_in(spi_in),
    .spi_out(so16), .mode(mode), .bus_in(bus_in16), .bus_out(bus_out16), .tx(tx16),
    .rx(rx16), .rx_ack(rx_ack), .rx_overrun(ovr16)
`ifdef SPI_SLAVE_WIDE_CRC_EN
    , .crc_rx_out(crc16)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every rx pulse must match the oldest queued word.
  always @(negedge clk) begin
    if (tx8) tx8_cnt++;
    if (rx8) begin
      rx8_cnt++;
      if (watch8) begin
        check("rx8_expected", 32'(q8.size() != 0), 32'd1);
        if (q8.size() != 0) check("bus_out8", 32'(bus_out8), q8.pop_front());
      end
    end
    if (rx16) begin
      rx16_cnt++;
      if (watch16) begin
        check("rx16_expected", 32'(q16.size() != 0), 32'd1);
        if (q16.size() != 0) check("bus_out16", 32'(bus_out16), q16.pop_front());
      end
    end
  end

  task automatic set_mode(input logic [1:0] m);
    @(negedge clk);
    mode     = m;
    cur_mode = m;
    spi_clk  = m[1];
    repeat (16) @(negedge clk);
  endtask

  task automatic ack();
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    @(negedge clk);
  endtask

  // SPI master: sends nbits of mosi, collects MISO from the selected instance.
  task automatic frame(input logic [31:0] mosi, input int nbits, input bit lsb_first,
                       input bit use16, input bit keep_low, output logic [31:0] miso);
    int pos;
    logic cpol, cpha;
    cpol = cur_mode[1];
    cpha = cur_mode[0];
    miso = '0;
    @(negedge clk);
    spi_ss = 1'b0;
    if (!cpha) spi_in = mosi[lsb_first ? 0 : nbits - 1];
    #HALF;
    for (int i = 0; i < nbits; i++) begin
      pos = lsb_first ? i : nbits - 1 - i;
      if (cpha) begin
        spi_clk = ~cpol;
        spi_in  = mosi[pos];
        #HALF;
        spi_clk   = cpol;
        miso[pos] = use16 ? so16 : so8;
        #HALF;
      end else begin
        spi_clk   = ~cpol;
        miso[pos] = use16 ? so16 : so8;
        #HALF;
        spi_clk = cpol;
        if (i + 1 < nbits) spi_in = mosi[lsb_first ? i + 1 : nbits - 2 - i];
        #HALF;
      end
    end
    if (!keep_low) begin
      spi_ss = 1'b1;
      #(2 * HALF);
    end
  endtask

  initial begin
    logic [31:0] miso;
    int rx0, tx0;
    rst = 1'b1; ena = 1'b1; spi_clk = 1'b0; spi_ss = 1'b1; spi_in = 1'b0;
    mode = 2'b00; rx_ack = 1'b0; bus_in8 = '0; bus_in16 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_bus_out", 32'(bus_out8), 32'h0);
    check("reset_spi_out", 32'(so8), 32'h0);
    check("reset_tx", 32'(tx8), 32'h0);
    check("reset_rx", 32'(rx8), 32'h0);
    check("reset_overrun", 32'(ovr8), 32'h0);
`ifdef SPI_SLAVE_WIDE_CRC_EN
    check("reset_crc", 32'(crc8), 32'h0);
`endif

    // Mode 0, single word.
    set_mode(2'b00);
    bus_in8 = 8'hA5;
    q8.push_back(32'h3C);
    rx0 = rx8_cnt; tx0 = tx8_cnt;
    frame(32'h3C, 8, 1'b0, 1'b0, 1'b0, miso);
    check("m0_miso", miso, 32'hA5);
    check("m0_rx_pulses", 32'(rx8_cnt - rx0), 32'd1);
    check("m0_tx_pulses", 32'(tx8_cnt - tx0), 32'd2);
    check("m0_no_overrun", 32'(ovr8), 32'h0);
    ack();

    // Two back-to-back words in one select period, no ack in between.
    bus_in8 = 8'h5A;
    q8.push_back(32'h55);
    q8.push_back(32'hC3);
    rx0 = rx8_cnt;
    frame(32'h55C3, 16, 1'b0, 1'b0, 1'b0, miso);
    check("two_word_miso", miso, 32'h5A5A);
    check("two_word_rx_pulses", 32'(rx8_cnt - rx0), 32'd2);
    check("overrun_set", 32'(ovr8), 32'h1);
    ack();
    check("overrun_cleared", 32'(ovr8), 32'h0);

    // Aborted 5-bit partial word, then a full word.
    rx0 = rx8_cnt;
    frame(32'h16, 5, 1'b0, 1'b0, 1'b0, miso);
    check("abort_no_rx", 32'(rx8_cnt - rx0), 32'd0);
    check("abort_bus_out_kept", 32'(bus_out8), 32'hC3);
    q8.push_back(32'h81);
    frame(32'h81, 8, 1'b0, 1'b0, 1'b0, miso);
    check("after_abort_rx_pulses", 32'(rx8_cnt - rx0), 32'd1);
    check("after_abort_no_overrun", 32'(ovr8), 32'h0);
    ack();

    // 16-bit LSB-first instance, mode 3.
    watch8  = 1'b0;
    watch16 = 1'b1;
    set_mode(2'b11);
    bus_in16 = 16'hBEEF;
    q16.push_back(32'h1234);
    rx0 = rx16_cnt;
    frame(32'h1234, 16, 1'b1, 1'b1, 1'b0, miso);
    check("m3_miso16", miso, 32'hBEEF);
    check("m3_rx16_pulses", 32'(rx16_cnt - rx0), 32'd1);
    watch16 = 1'b0;
    watch8  = 1'b1;

    // Reset in the middle of a mode-1 word.
    set_mode(2'b01);
    bus_in8 = 8'h3C;
    frame(32'hF0, 3, 1'b0, 1'b0, 1'b1, miso);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_bus_out", 32'(bus_out8), 32'h0);
    check("rst_spi_out", 32'(so8), 32'h0);
    check("rst_tx", 32'(tx8), 32'h0);
    check("rst_rx", 32'(rx8), 32'h0);
    check("rst_overrun", 32'(ovr8), 32'h0);
    check("rst_bus_out16", 32'(bus_out16), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // Clocks while still selected after reset must be ignored.
    rx0 = rx8_cnt;
    for (int i = 0; i < 8; i++) begin
      spi_clk = ~spi_clk;
      #HALF;
    end
    spi_ss = 1'b1;
    set_mode(2'b01);
    check("post_rst_no_rx", 32'(rx8_cnt - rx0), 32'd0);
    q8.push_back(32'h96);
    rx0 = rx8_cnt; tx0 = tx8_cnt;
    frame(32'h96, 8, 1'b0, 1'b0, 1'b0, miso);
    check("m1_miso", miso, 32'h3C);
    check("m1_rx_pulses", 32'(rx8_cnt - rx0), 32'd1);
    check("m1_tx_pulses", 32'(tx8_cnt - tx0), 32'd1);
    ack();

    // Clock enable low: the frame must be ignored entirely.
    @(negedge clk);
    ena = 1'b0;
    rx0 = rx8_cnt;
    frame(32'hE7, 8, 1'b0, 1'b0, 1'b0, miso);
    check("ena_low_no_rx", 32'(rx8_cnt - rx0), 32'd0);
    check("ena_low_bus_out", 32'(bus_out8), 32'h96);
    @(negedge clk);
    ena = 1'b1;
    repeat (8) @(negedge clk);

`ifdef SPI_SLAVE_WIDE_CRC_EN
    set_mode(2'b00);
    q8.push_back(32'h01);
    frame(32'h01, 8, 1'b0, 1'b0, 1'b0, miso);
    check("crc_01", 32'(crc8), 32'h07);
    ack();
    q8.push_back(32'hFF);
    frame(32'hFF, 8, 1'b0, 1'b0, 1'b0, miso);
    check("crc_ff", 32'(crc8), 32'hF3);
    ack();
`endif

    repeat (8) @(negedge clk);
    check("q8_drained", 32'(q8.size()), 32'd0);
    check("q16_drained", 32'(q16.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave_wide.md
SPI_SLAVE_WIDE -- requirements
Module: spi_slave_wide

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning word length in bits (legal 4..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning 1 = MSB shifted first, 0 = LSB first.
REQ-003 SHALL have ports: clk  input  1  system clock; rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: ena  input  1  clock enable for all sequential logic except reset.
REQ-005 SHALL have ports: spi_clk  input  1  SPI serial clock, asynchronous to clk.
REQ-006 SHALL have ports: spi_ss  input  1  slave select, active-low.
REQ-007 SHALL have ports: spi_in  input  1  MOSI; spi_out  output  1  MISO.
REQ-008 SHALL have ports: mode  input  2  {CPOL,CPHA}, sampled only while spi_ss high.
REQ-009 SHALL have ports: bus_in  input  WIDTH  transmit word; bus_out  output  WIDTH  last complete received word.
REQ-010 SHALL have ports: tx  output  1  one-cycle pulse, bus_in captured; rx  output  1  one-cycle pulse, bus_out updated.
REQ-011 SHALL have ports: rx_ack  input  1  host read acknowledge; rx_overrun  output  1  sticky overrun flag.
REQ-012 SHALL have ports (only with macro): crc_rx_out  output  8  CRC-8 of received bits.

Function
REQ-013 spi_clk, spi_ss, spi_in SHALL pass through a 2-flop synchroniser; spi_clk edges detected from stages 2/3 (rise = s2&~s3, fall = ~s2&s3).
REQ-014 Mode register SHALL load from mode on every clk while synced spi_ss high; held while low.
REQ-015 Sample edge SHALL be rising spi_clk when CPOL==CPHA, falling otherwise; shift edge is the opposite.
REQ-016 On sample edge: receive shift register shifts in spi_in (MSB_FIRST=1: into bit 0, shift left; else into bit WIDTH-1, shift right); bit counter increments, wraps at WIDTH-1 -> 0.
REQ-017 When counter wraps, bus_out SHALL load the completed word and rx SHALL pulse on the next clk; bus_out holds until next completed word.
REQ-018 CPHA=0: tx shift register SHALL load bus_in on synced spi_ss falling and on each sample edge that completes a word; tx pulses in that cycle.
REQ-019 CPHA=1: tx shift register SHALL load bus_in on the first shift edge of each word; tx pulses in that cycle; other shift edges shift.
REQ-020 spi_out SHALL be tx shift register bit WIDTH-1 (MSB_FIRST=1) or bit 0 (MSB_FIRST=0); 0 while spi_ss high.
REQ-021 rx_overrun SHALL set when rx pulses and no rx_ack since previous rx; rx_ack clears it; rx and rx_ack same cycle -> word counted as unread, flag not set by that rx.
REQ-022 spi_ss rising mid-word SHALL clear bit counter, shift registers and edge detectors; bus_out, rx_overrun unchanged; no rx pulse.
REQ-023 ena low SHALL freeze all state; pulses do not stretch.

Reset
REQ-024 rst SHALL asynchronously clear: synchronisers, mode register (mode 0), counter, shift registers, bus_out=0, spi_out=0, tx=0, rx=0, rx_overrun=0, crc_rx_out=0.
REQ-025 Mid-transfer rst SHALL abort the word; after release the slave waits for spi_ss falling.

Configuration
REQ-026 Macro SPI_SLAVE_WIDE_CRC_EN defined: CRC-8, poly 0x07, init 0x00, SHALL update on each sample edge with spi_in, cleared on spi_ss high; crc_rx_out latches it with each rx pulse.
REQ-027 Macro undefined: no CRC logic, crc_rx_out port absent.

Verification
REQ-028 WIDTH=8, mode 0, MSB_FIRST=1, bus_in=0xA5, master sends 0x3C -> MISO 1,0,1,0,0,1,0,1; bus_out=0x3C; one rx pulse.
REQ-029 WIDTH=16, mode 3, MSB_FIRST=0, master sends 0x1234, bus_in=0xBEEF -> bus_out=0x1234; MISO LSB-first 0xBEEF.
REQ-030 Two 8-bit words, no rx_ack -> rx_overrun=1 after second rx; rx_ack -> 0.
REQ-031 spi_ss raised after 5 bits, then full word 0x81 -> bus_out=0x81, exactly one rx pulse.
REQ-032 With SPI_SLAVE_WIDE_CRC_EN, master sends 0x01 -> crc_rx_out=0x07; 0xFF -> 0xF3.
REQ-033 rst asserted mid-word in mode 1 -> all outputs 0 immediately; next word after spi_ss cycle received correctly.
